// File: rtl/uart_rx_oversample.sv
// UART receiver with 16x oversampling, optional parity, and break handling.
// Baud, parity enable and parity type are captured at the start edge and held for the frame.
module uart_rx_oversample #(
  parameter int n                = 8,
  parameter int CLK_DIV_OVERRIDE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         Rx,
  input  logic [2:0]   baud_rateSel,
  input  logic         include_parity,
  input  logic         parity_type,
  output logic [n-1:0] data,
  output logic         valid,
  output logic         parity_err,
  output logic         frame_err,
  output logic         correct,
  output logic         Rx_idle
);

  localparam int BW = $clog2(n) + 1;
  localparam logic [9:0] DIV_OVR = CLK_DIV_OVERRIDE[9:0];

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  function automatic logic [9:0] div_for(input logic [2:0] sel);
    logic [9:0] d;
    case (sel)
      3'd0:    d = 10'd651;
      3'd1:    d = 10'd326;
      3'd2:    d = 10'd163;
      3'd3:    d = 10'd109;
      3'd4:    d = 10'd54;
      default: d = 10'd651;
    endcase
    if (DIV_OVR != 10'd0) begin
      d = DIV_OVR;
    end else begin
      d = d;
    end
    return d;
  endfunction

  // Even type: error when the total count of ones is odd; odd type: the reverse.
  function automatic logic parity_mismatch(input logic [n-1:0] d, input logic pb, input logic even);
    return (^{d, pb}) ^ ~even;
  endfunction

  state_t          state_r, state_next;
  logic            rx_meta_r, rx_sync_r, rx_prev_r;
  logic [2:0]      sel_r;
  logic            inc_par_r, par_type_r;
  logic [9:0]      tick_cnt_r;
  logic [3:0]      os_cnt_r;
  logic [BW-1:0]   bit_cnt_r;
  logic [n-1:0]    shift_r;
  logic            pbit_r, stop_r, fin_r;

  logic       fall_s, tick_s, half_s, bit_end_s;
  logic [9:0] div_s;

  assign fall_s    = rx_prev_r & ~rx_sync_r;
  assign div_s     = div_for((state_r == IDLE) ? baud_rateSel : sel_r);
  assign tick_s    = (tick_cnt_r == (div_s - 10'd1));
  assign half_s    = tick_s && (os_cnt_r == 4'd7);
  assign bit_end_s = tick_s && (os_cnt_r == 4'd15);

  // Two-flop synchronizer plus previous-value flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= Rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE:      if (fall_s) state_next = START; else state_next = IDLE;
      START: begin
        if (half_s) begin
          state_next = rx_sync_r ? IDLE : DATA;
        end else begin
          state_next = START;
        end
      end
      DATA: begin
        if (bit_end_s && (bit_cnt_r == BW'(n - 1))) begin
          state_next = inc_par_r ? PARITY : STOP;
        end else begin
          state_next = DATA;
        end
      end
      PARITY:    if (bit_end_s) state_next = STOP; else state_next = PARITY;
      STOP: begin
        if (bit_end_s) begin
          state_next = rx_sync_r ? IDLE : WAIT_HIGH;
        end else begin
          state_next = STOP;
        end
      end
      WAIT_HIGH: if (rx_sync_r) state_next = IDLE; else state_next = WAIT_HIGH;
      default:   state_next = IDLE;
    endcase
  end

  // Tick and oversample counters; the range check keeps a shrinking divisor from overrunning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_r <= 10'd0;
      os_cnt_r   <= 4'd0;
    end else begin
      if ((state_r == IDLE) && fall_s) begin
        tick_cnt_r <= 10'd0;
      end else if (tick_cnt_r >= (div_s - 10'd1)) begin
        tick_cnt_r <= 10'd0;
      end else begin
        tick_cnt_r <= tick_cnt_r + 10'd1;
      end
      if ((state_r == IDLE) || ((state_r == START) && half_s)) begin
        os_cnt_r <= 4'd0;
      end else if (tick_s) begin
        os_cnt_r <= os_cnt_r + 4'd1;
      end else begin
        os_cnt_r <= os_cnt_r;
      end
    end
  end

  // Frame datapath: configuration capture, shift register, parity and stop samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r      <= 3'd0;
      inc_par_r  <= 1'b0;
      par_type_r <= 1'b0;
      bit_cnt_r  <= '0;
      shift_r    <= '0;
      pbit_r     <= 1'b0;
      stop_r     <= 1'b0;
      fin_r      <= 1'b0;
    end else begin
      fin_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (fall_s) begin
            sel_r      <= baud_rateSel;
            inc_par_r  <= include_parity;
            par_type_r <= parity_type;
          end
        end
        START:  bit_cnt_r <= '0;
        DATA: begin
          if (bit_end_s) begin
            shift_r   <= {rx_sync_r, shift_r[n-1:1]};
            bit_cnt_r <= bit_cnt_r + BW'(1);
          end
        end
        PARITY: if (bit_end_s) pbit_r <= rx_sync_r;
        STOP: begin
          if (bit_end_s) begin
            stop_r <= rx_sync_r;
            fin_r  <= 1'b1;
          end
        end
        default: fin_r <= 1'b0;
      endcase
    end
  end

  // Registered outputs, updated one clock after the stop sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      correct    <= 1'b0;
      Rx_idle    <= 1'b1;
    end else begin
      valid   <= fin_r;
      Rx_idle <= (state_next == IDLE);
      if (fin_r) begin
        data       <= shift_r;
        parity_err <= inc_par_r & parity_mismatch(shift_r, pbit_r, par_type_r);
        frame_err  <= ~stop_r;
        correct    <= stop_r & ~(inc_par_r & parity_mismatch(shift_r, pbit_r, par_type_r));
      end
    end
  end

endmodule

// File: doc/uart_rx_oversample.md
UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 SHALL have parameter n, default 8, data bits per frame.
REQ-002 SHALL have parameter CLK_DIV_OVERRIDE, default 0; when nonzero it is the 16x-tick divisor for all baud selections.
REQ-003 SHALL have port clk  input  1  system clock, 100 MHz; the block's one clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Rx  input  1  serial line, idle high, asynchronous to clk.
REQ-006 SHALL have port baud_rateSel  input  3  baud select.
REQ-007 SHALL have port include_parity  input  1  1 = frame carries a parity bit.
REQ-008 SHALL have port parity_type  input  1  1 = even, 0 = odd.
REQ-009 SHALL have port data  output  n  last received data word.
REQ-010 SHALL have port valid  output  1  one-cycle pulse per completed frame.
REQ-011 SHALL have port parity_err  output  1  parity mismatch in last frame.
REQ-012 SHALL have port frame_err  output  1  stop bit sampled low in last frame.
REQ-013 SHALL have port correct  output  1  = valid-frame data with no parity_err and no frame_err.
REQ-014 SHALL have port Rx_idle  output  1  high only in IDLE state.

Function
REQ-015 SHALL pass Rx through a 2-FF synchronizer; all logic uses the synchronized value only.
REQ-016 SHALL generate a 16x tick: counter 0..DIV-1, tick for one clk when count = DIV-1.
REQ-017 SHALL set DIV to 651/326/163/109/54 for baud_rateSel 0/1/2/3/4 (9600/19200/38400/57600/115200), and 651 for 5-7, unless CLK_DIV_OVERRIDE is nonzero.
REQ-018 SHALL use states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-019 IDLE: on a synchronized 1->0 transition SHALL clear the tick counter and oversample count, latch baud_rateSel, include_parity and parity_type, and go to START.
REQ-020 START: SHALL sample on the 8th tick; if the sample is 0, go to DATA; if it is 1, treat it as a false start and return to IDLE with no output change.
REQ-021 DATA: SHALL sample every 16th tick and shift in n bits LSB first, then go to PARITY if the latched include_parity is set, else to STOP.
REQ-022 PARITY: SHALL sample after 16 ticks; the expected bit makes the total 1s in data+parity even (parity_type=1) or odd (parity_type=0).
REQ-023 STOP: SHALL sample after 16 ticks.
  - On the next clk: load data, set parity_err (0 if parity disabled), set frame_err = !sample, pulse valid for 1 clk.
  - Sample 1 -> IDLE; sample 0 -> WAIT_HIGH.
REQ-024 WAIT_HIGH: SHALL ignore Rx until the synchronized Rx is 1, then go to IDLE; a held-low break line therefore produces exactly one frame.
REQ-025 data, parity_err, frame_err and correct SHALL hold their values until the next valid pulse.
REQ-026 Changes to baud_rateSel, include_parity or parity_type mid-frame SHALL not affect the frame in progress.
REQ-027 The tick counter SHALL free-run in IDLE and never wrap past DIV-1.

Reset
REQ-028 While rst_n = 0: state = IDLE, data = 0, valid = 0, parity_err = 0, frame_err = 0, correct = 0, Rx_idle = 1, synchronizer flops = 1, counters = 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no valid pulse; after release the block waits for a new falling edge.

Verification (CLK_DIV_OVERRIDE = 4, so 1 bit = 64 clk)
REQ-030 Frame 0xA5, no parity, stop = 1 -> one valid pulse about 10 bit times after the start edge; data = 0xA5, errors = 0, correct = 1, Rx_idle returns to 1.
REQ-031 0x3C with even parity:
  - parity bit 0 -> parity_err = 0, correct = 1.
  - parity bit 1 -> parity_err = 1, correct = 0.
  - Odd parity with bit 1 -> parity_err = 0.
REQ-032 Rx low pulse of 16 clk (shorter than half a bit) -> no valid pulse, Rx_idle returns to 1, data unchanged.
REQ-033 0x55 with stop bit 0 and Rx then held low for 30 bit times -> one valid with frame_err = 1, data = 0x55, Rx_idle = 0 until Rx goes high, no second valid.
REQ-034 rst_n pulsed low during bit 4 of a frame -> all outputs at reset values, no valid pulse; a following 0x81 frame is received correctly.
